m92_cpu_mem_responder: RTL and testbench

// - Responder side of the CPU memory decode: serves rom_memrq/ram_memrq cycles carrying a translated SDRAM word address.
// - Turns each CPU cycle into one SDRAM req/ack transaction and returns read data with a one-cycle cpu_ready pulse.
// - Holds a one-entry read cache so repeated fetches of the same word skip SDRAM. Drops writes to non-writable space.
// - Sits between the V33 bus interface and the SDRAM arbiter CPU port.

---
 rtl/m92_cpu_mem_responder_if.sv | 36 +++
 rtl/m92_cpu_mem_responder.sv | 138 +++++++++++++
 tb/tb_m92_cpu_mem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/m92_cpu_mem_responder_if.sv
// m92_cpu_mem_responder_if: CPU-side bus and SDRAM arbiter port of the memory responder.
//   slave  : responder view (cpu_* requests and sdr_ack/sdr_rdata in; cpu_dout/ready/error and sdr_* requests out)
//   master : mirror view used by whatever drives the CPU cycles and plays the SDRAM arbiter
interface m92_cpu_mem_responder_if #(parameter int ADDR_W = 25);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_be;
    logic [15:0]       cpu_din;
    logic [ADDR_W-1:0] mem_addr;
    logic              rom_memrq;
    logic              ram_memrq;
    logic              writable;
    logic [15:0]       cpu_dout;
    logic              cpu_ready;
    logic              bus_error;
    logic              sdr_req;
    logic              sdr_we;
    logic [ADDR_W-1:0] sdr_addr;
    logic [1:0]        sdr_be;
    logic [15:0]       sdr_wdata;
    logic              sdr_ack;
    logic [15:0]       sdr_rdata;
    logic              cache_flush;

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_din, mem_addr, rom_memrq, ram_memrq, writable,
        input  sdr_ack, sdr_rdata, cache_flush,
        output cpu_dout, cpu_ready, bus_error, sdr_req, sdr_we, sdr_addr, sdr_be, sdr_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_din, mem_addr, rom_memrq, ram_memrq, writable,
        output sdr_ack, sdr_rdata, cache_flush,
        input  cpu_dout, cpu_ready, bus_error, sdr_req, sdr_we, sdr_addr, sdr_be, sdr_wdata
    );
endinterface

// File: rtl/m92_cpu_mem_responder.sv
// m92_cpu_mem_responder: turns CPU memory cycles into SDRAM req/ack transactions with a one-entry read cache.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : cpu_* cycle in, cpu_dout/cpu_ready/bus_error out, sdr_* arbiter port, cache_flush
module m92_cpu_mem_responder #(
    parameter int ADDR_W   = 25,
    parameter int TIMEOUT  = 255,
    parameter bit CACHE_EN = 1'b1
) (
    input logic                    clk,
    input logic                    reset_n,
    m92_cpu_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state, state_d;
    logic [7:0]        cnt, cnt_d;
    logic              req_q, req_d, we_q, we_d, err_q, err_d, c_valid, c_valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d, c_tag, c_tag_d, word;
    logic [1:0]        be_q, be_d;
    logic [15:0]       wdata_q, wdata_d, dout_q, dout_d, c_data, c_data_d;
    logic              hit, tag_match;

    // Word address: bit 0 cleared so odd and even byte addresses share one cache tag.
    assign word      = bus.mem_addr & ~ADDR_W'(1);
    assign hit       = CACHE_EN && c_valid && c_tag == word;
    assign tag_match = c_valid && c_tag == addr_q;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        req_d     = req_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        c_valid_d = c_valid;
        c_tag_d   = c_tag;
        c_data_d  = c_data;
        unique case (state)
            IDLE: if (bus.cpu_req) begin
                err_d = 1'b0;
                if (!(bus.rom_memrq || bus.ram_memrq)) begin
                    state_d = DONE;
                    dout_d  = 16'hFFFF;
                end else if (bus.cpu_we) begin
                    if (bus.writable && !bus.rom_memrq) begin
                        state_d = WR;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = word;
                        be_d    = bus.cpu_be;
                        wdata_d = bus.cpu_din;
                    end else
                        state_d = DONE;
                end else if (hit) begin
                    state_d = DONE;
                    dout_d  = c_data;
                end else begin
                    state_d = RD;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = word;
                    be_d    = 2'b11;
                end
            end
            RD, WR: begin
                cnt_d = cnt + 8'd1;
                if (bus.sdr_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (state == RD) begin
                        dout_d    = bus.sdr_rdata;
                        c_tag_d   = addr_q;
                        c_data_d  = bus.sdr_rdata;
                        c_valid_d = CACHE_EN;
                    end else if (tag_match)
                        // Keep the cached word coherent with what SDRAM now holds.
                        c_data_d = {be_q[1] ? wdata_q[15:8] : c_data[15:8],
                                    be_q[0] ? wdata_q[7:0]  : c_data[7:0]};
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    err_d   = 1'b1;
                    dout_d  = 16'hFFFF;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: state_d = IDLE;
        endcase
        // Flush beats a same-cycle fill so a bank switch never leaves stale data valid.
        if (bus.cache_flush)
            c_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            c_valid <= 1'b0;
            c_tag   <= '0;
            c_data  <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            c_valid <= c_valid_d;
            c_tag   <= c_tag_d;
            c_data  <= c_data_d;
        end
    end

    assign bus.sdr_req   = req_q;
    assign bus.sdr_we    = we_q;
    assign bus.sdr_addr  = addr_q;
    assign bus.sdr_be    = be_q;
    assign bus.sdr_wdata = wdata_q;
    assign bus.cpu_dout  = dout_q;
    assign bus.cpu_ready = state == DONE;
    assign bus.bus_error = state == DONE && err_q;
endmodule

// File: tb/tb_m92_cpu_mem_responder.sv
// tb_m92_cpu_mem_responder: directed cycles against a transaction-level cache/latency model.
module tb_m92_cpu_mem_responder;
    logic clk;
    logic reset_n;
    int   n_chk, n_fail, cyc;
    int   t_req_lo, t_req_hi, t_rdy, rdy_cyc, req_cycles;
    logic e_we, e_err, e_dchk, in_req;
    logic [24:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_wdata, e_dout, last_dout;
    logic        last_err;
    logic        m_valid;
    logic [24:0] m_tag;
    logic [15:0] m_data;

    m92_cpu_mem_responder_if #(.ADDR_W(25)) bus ();

    m92_cpu_mem_responder #(.ADDR_W(25), .TIMEOUT(255), .CACHE_EN(1'b1)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, #1 after the active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!reset_n) begin
            chk("rst_sdr_req", bus.sdr_req, 0);
            chk("rst_sdr_we", bus.sdr_we, 0);
            chk("rst_sdr_addr", bus.sdr_addr, 0);
            chk("rst_sdr_be", bus.sdr_be, 0);
            chk("rst_sdr_wdata", bus.sdr_wdata, 0);
            chk("rst_cpu_ready", bus.cpu_ready, 0);
            chk("rst_bus_error", bus.bus_error, 0);
            chk("rst_cpu_dout", bus.cpu_dout, 0);
        end else begin
            in_req = cyc >= t_req_lo && cyc <= t_req_hi;
            chk("sdr_req", bus.sdr_req, in_req);
            if (in_req) begin
                chk("sdr_we", bus.sdr_we, e_we);
                chk("sdr_addr", bus.sdr_addr, e_addr);
                chk("sdr_be", bus.sdr_be, e_be);
                if (e_we)
                    chk("sdr_wdata", bus.sdr_wdata, e_wdata);
            end
            if (bus.sdr_req)
                req_cycles++;
            chk("cpu_ready", bus.cpu_ready, cyc == t_rdy);
            chk("bus_error", bus.bus_error, cyc == t_rdy && e_err);
            if (bus.cpu_ready) begin
                rdy_cyc   = cyc;
                last_dout = bus.cpu_dout;
                last_err  = bus.bus_error;
            end
            if (cyc == t_rdy && e_dchk)
                chk("cpu_dout", bus.cpu_dout, e_dout);
        end
    end

    // One CPU cycle. ack_after = cycle of sdr_req at which the arbiter acks (1 = first); 0 = never.
    task automatic run(input logic we, input logic [1:0] be, input logic [15:0] din, input logic [24:0] addr,
                       input logic rom, input logic ram, input logic wr, input int ack_after,
                       input logic [15:0] rdata, input logic flush);
        logic [24:0] w;
        logic        sdr, tmo;
        int          k;
        w   = {addr[24:1], 1'b0};
        sdr = 1'b0;
        tmo = ack_after < 1;
        k   = tmo ? 255 : ack_after;
        @(negedge clk);
        e_err  = 1'b0;
        e_dchk = 1'b0;
        if (!(rom || ram)) begin
            e_dout = 16'hFFFF;
            e_dchk = 1'b1;
        end else if (we)
            sdr = wr && !rom;
        else if (m_valid && m_tag == w) begin
            e_dout = m_data;
            e_dchk = 1'b1;
        end else
            sdr = 1'b1;
        if (sdr) begin
            if (tmo) begin
                e_err  = 1'b1;
                e_dout = 16'hFFFF;
                e_dchk = 1'b1;
            end else if (we) begin
                if (m_valid && m_tag == w) begin
                    if (be[1]) m_data[15:8] = din[15:8];
                    if (be[0]) m_data[7:0] = din[7:0];
                end
            end else begin
                e_dout  = rdata;
                e_dchk  = 1'b1;
                m_valid = !flush;
                m_tag   = w;
                m_data  = rdata;
            end
        end
        e_we       = we;
        e_addr     = w;
        e_be       = we ? be : 2'b11;
        e_wdata    = din;
        t_req_lo   = cyc + 1;
        t_req_hi   = sdr ? cyc + k : cyc;
        t_rdy      = sdr ? cyc + k + 1 : cyc + 1;
        req_cycles = 0;
        bus.cpu_we = we; bus.cpu_be = be; bus.cpu_din = din; bus.mem_addr = addr;
        bus.rom_memrq = rom; bus.ram_memrq = ram; bus.writable = wr;
        bus.cpu_req = 1'b1;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        if (sdr && !tmo) begin
            repeat (k - 1) @(negedge clk);
            bus.sdr_ack = 1'b1;
            bus.sdr_rdata = rdata;
            bus.cache_flush = flush;
            @(negedge clk);
            bus.sdr_ack = 1'b0;
            bus.cache_flush = 1'b0;
        end
        while (cyc <= t_rdy) @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        t_req_lo = 1; t_req_hi = 0; t_rdy = -1; rdy_cyc = 0; req_cycles = 0;
        e_we = 0; e_err = 0; e_dchk = 0; e_addr = '0; e_be = '0; e_wdata = '0; e_dout = '0;
        last_dout = '0; last_err = 0; m_valid = 0; m_tag = '0; m_data = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_be = 0; bus.cpu_din = 0; bus.mem_addr = 0;
        bus.rom_memrq = 0; bus.ram_memrq = 0; bus.writable = 0;
        bus.sdr_ack = 0; bus.sdr_rdata = 0; bus.cache_flush = 0;
        reset_n = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);

        run(0, 2'b11, 16'h0, 25'h0012346, 0, 1, 1, 4, 16'hBEEF, 0);
        chk("miss_dout", last_dout, 16'hBEEF);
        chk("miss_req_cycles", req_cycles, 4);
        run(0, 2'b11, 16'h0, 25'h0012346, 0, 1, 1, 4, 16'h0000, 0);
        chk("hit_dout", last_dout, 16'hBEEF);
        chk("hit_no_req", req_cycles, 0);
        chk("hit_latency", rdy_cyc - t_req_lo + 1, 1);
        run(1, 2'b01, 16'h12AB, 25'h0012346, 0, 1, 1, 2, 16'h0000, 0);
        chk("model_merge", m_data, 16'hBEAB);
        run(0, 2'b11, 16'h0, 25'h0012346, 0, 1, 1, 3, 16'h0000, 0);
        chk("merge_hit_dout", last_dout, 16'hBEAB);
        run(1, 2'b11, 16'h5555, 25'h0012346, 1, 0, 1, 2, 16'h0000, 0);
        chk("rom_wr_no_req", req_cycles, 0);
        run(1, 2'b11, 16'h6666, 25'h0012346, 0, 1, 0, 2, 16'h0000, 0);
        run(0, 2'b11, 16'h0, 25'h0012347, 0, 1, 1, 3, 16'h0000, 0);
        chk("odd_addr_hit", last_dout, 16'hBEAB);
        run(0, 2'b11, 16'h0, 25'h0000300, 0, 0, 1, 3, 16'h0000, 0);
        chk("no_memrq_dout", last_dout, 16'hFFFF);
        run(0, 2'b11, 16'h0, 25'h1FFFFFE, 1, 0, 0, 1, 16'h1234, 0);
        chk("min_latency", rdy_cyc - t_req_lo + 1, 2);
        run(0, 2'b11, 16'h0, 25'h1FFFFFF, 1, 0, 0, 1, 16'h0000, 0);
        chk("rom_hit_dout", last_dout, 16'h1234);
        run(1, 2'b10, 16'hA5C3, 25'h0000400, 0, 1, 1, 1, 16'h0000, 0);
        run(0, 2'b11, 16'h0, 25'h0012346, 0, 1, 1, 3, 16'h7777, 0);
        run(0, 2'b11, 16'h0, 25'h0000100, 0, 1, 1, 0, 16'h0000, 0);
        chk("timeout_req_cycles", req_cycles, 255);
        chk("timeout_err", last_err, 1);
        chk("timeout_dout", last_dout, 16'hFFFF);
        @(negedge clk) bus.sdr_ack = 1'b1; bus.sdr_rdata = 16'hDEAD;
        @(negedge clk) bus.sdr_ack = 1'b0;
        repeat (2) @(negedge clk);
        run(0, 2'b11, 16'h0, 25'h0012346, 0, 1, 1, 3, 16'h0000, 0);
        chk("hit_after_timeout", last_dout, 16'h7777);
        run(0, 2'b11, 16'h0, 25'h0000200, 0, 1, 1, 3, 16'h5A5A, 1);
        chk("flush_fill_dout", last_dout, 16'h5A5A);
        run(0, 2'b11, 16'h0, 25'h0000200, 0, 1, 1, 2, 16'h6B6B, 0);
        chk("flush_fill_miss", req_cycles, 2);
        @(negedge clk) bus.cache_flush = 1'b1; m_valid = 1'b0;
        @(negedge clk) bus.cache_flush = 1'b0;
        run(0, 2'b11, 16'h0, 25'h0000200, 0, 1, 1, 1, 16'h0F0F, 0);
        chk("idle_flush_miss", req_cycles, 1);

        // Reset in the middle of a read miss.
        @(negedge clk);
        e_we = 0; e_addr = 25'h0000500; e_be = 2'b11; req_cycles = 0;
        t_req_lo = cyc + 1; t_req_hi = cyc + 1000; t_rdy = -1;
        bus.cpu_we = 0; bus.mem_addr = 25'h0000500; bus.rom_memrq = 0; bus.ram_memrq = 1; bus.cpu_req = 1;
        @(negedge clk) bus.cpu_req = 0;
        repeat (2) @(negedge clk);
        reset_n = 0;
        t_req_hi = 0;
        #1;
        chk("midrst_req_drop", bus.sdr_req, 0);
        chk("midrst_no_ready", bus.cpu_ready, 0);
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        run(0, 2'b11, 16'h0, 25'h0000200, 0, 1, 1, 2, 16'h3C3C, 0);
        chk("post_rst_miss", req_cycles, 2);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
